// File: rtl/piso_serializer.sv
// Parallel-in, serial-out transmitter with valid/last framing and clock enable.
// Define SERIALIZER_PARITY_EN to append an even-parity bit after the data bits.
module piso_serializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             ce,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             ser_last,
  output logic             busy
);

`ifdef SERIALIZER_PARITY_EN
  localparam int FLEN = WIDTH + 1;
`else
  localparam int FLEN = WIDTH;
`endif
  localparam int CNT_W = $clog2(FLEN + 1);
  localparam logic [CNT_W-1:0] FLEN_M1 = CNT_W'(FLEN - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] shreg_reg, shreg_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             ser_out_reg, ser_out_next;
  logic             ser_valid_reg, ser_valid_next;
  logic             ser_last_reg, ser_last_next;
  logic [WIDTH-1:0] data_ord;
  logic             accept;

  // Reorder the word so the shifter always works MSB-first.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_ord
      if (MSB_FIRST) begin : g_msb
        assign data_ord[gi] = load_data[gi];
      end else begin : g_lsb
        assign data_ord[gi] = load_data[WIDTH-1-gi];
      end
    end
  endgenerate

  assign load_ready = ce && (state_reg == IDLE || (state_reg == SHIFT && ser_last_reg));
  assign accept     = load_valid && load_ready;
  assign ser_out    = ser_out_reg;
  assign ser_valid  = ser_valid_reg;
  assign ser_last   = ser_last_reg;
  assign busy       = (state_reg == SHIFT);

`ifdef SERIALIZER_PARITY_EN
  logic parity_reg, parity_next;
`endif

  always_comb begin
    state_next     = state_reg;
    shreg_next     = shreg_reg;
    cnt_next       = cnt_reg;
    ser_out_next   = ser_out_reg;
    ser_valid_next = ser_valid_reg;
    ser_last_next  = ser_last_reg;
`ifdef SERIALIZER_PARITY_EN
    parity_next    = parity_reg;
`endif
    if (accept) begin
      // First bit goes out straight away; the rest wait in the shifter.
      state_next     = SHIFT;
      ser_out_next   = data_ord[WIDTH-1];
      shreg_next     = {data_ord[WIDTH-2:0], 1'b0};
      cnt_next       = CNT_ONE;
      ser_valid_next = 1'b1;
      ser_last_next  = 1'b0;
`ifdef SERIALIZER_PARITY_EN
      parity_next    = ^load_data;
`endif
    end else if (ce && state_reg == SHIFT) begin
      if (ser_last_reg) begin
        state_next     = IDLE;
        shreg_next     = '0;
        cnt_next       = '0;
        ser_out_next   = 1'b0;
        ser_valid_next = 1'b0;
        ser_last_next  = 1'b0;
      end else begin
        cnt_next      = cnt_reg + CNT_ONE;
        ser_last_next = (cnt_reg == FLEN_M1);
        ser_out_next  = shreg_reg[WIDTH-1];
        shreg_next    = {shreg_reg[WIDTH-2:0], 1'b0};
`ifdef SERIALIZER_PARITY_EN
        if (cnt_reg == CNT_W'(WIDTH)) begin
          ser_out_next = parity_reg;
        end
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= IDLE;
      shreg_reg     <= '0;
      cnt_reg       <= '0;
      ser_out_reg   <= 1'b0;
      ser_valid_reg <= 1'b0;
      ser_last_reg  <= 1'b0;
`ifdef SERIALIZER_PARITY_EN
      parity_reg    <= 1'b0;
`endif
    end else begin
      state_reg     <= state_next;
      shreg_reg     <= shreg_next;
      cnt_reg       <= cnt_next;
      ser_out_reg   <= ser_out_next;
      ser_valid_reg <= ser_valid_next;
      ser_last_reg  <= ser_last_next;
`ifdef SERIALIZER_PARITY_EN
      parity_reg    <= parity_next;
`endif
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Checks an MSB-first and an LSB-first serializer side by side against a
// frame-position model built from each accepted word.
module tb_piso_serializer;
  localparam int WIDTH = 8;
`ifdef SERIALIZER_PARITY_EN
  localparam int FLEN = WIDTH + 1;
`else
  localparam int FLEN = WIDTH;
`endif

  logic clk = 1'b0;
  logic reset_n, ce, load_valid;
  logic [WIDTH-1:0] load_data;
  logic load_ready_m, ser_out_m, ser_valid_m, ser_last_m, busy_m;
  logic load_ready_l, ser_out_l, ser_valid_l, ser_last_l, busy_l;

  always #5 clk = ~clk;

  piso_serializer #(.WIDTH(WIDTH), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .reset_n(reset_n), .ce(ce), .load_valid(load_valid),
    .load_ready(load_ready_m), .load_data(load_data), .ser_out(ser_out_m),
    .ser_valid(ser_valid_m), .ser_last(ser_last_m), .busy(busy_m)
  );

  piso_serializer #(.WIDTH(WIDTH), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .reset_n(reset_n), .ce(ce), .load_valid(load_valid),
    .load_ready(load_ready_l), .load_data(load_data), .ser_out(ser_out_l),
    .ser_valid(ser_valid_l), .ser_last(ser_last_l), .busy(busy_l)
  );

  int   checks = 0;
  int   errors = 0;
  logic fb_m [FLEN];
  logic fb_l [FLEN];
  int   pos = -1;        // index of the bit being presented, -1 when idle
  logic last_acc = 1'b0;
  logic [WIDTH-1:0] obs_m, obs_l;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chkw(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic void build(input logic [WIDTH-1:0] w);
    for (int k = 0; k < WIDTH; k++) begin
      fb_m[k] = w[WIDTH-1-k];
      fb_l[k] = w[k];
    end
`ifdef SERIALIZER_PARITY_EN
    fb_m[WIDTH] = ^w;
    fb_l[WIDTH] = ^w;
`endif
  endfunction

  task automatic check_out();
    logic act;
    act = (pos >= 0);
    chk1("ser_valid_m", ser_valid_m, act);
    chk1("ser_valid_l", ser_valid_l, act);
    chk1("ser_out_m", ser_out_m, act ? fb_m[pos] : 1'b0);
    chk1("ser_out_l", ser_out_l, act ? fb_l[pos] : 1'b0);
    chk1("ser_last_m", ser_last_m, pos == FLEN - 1);
    chk1("ser_last_l", ser_last_l, pos == FLEN - 1);
    chk1("busy_m", busy_m, act);
    chk1("busy_l", busy_l, act);
  endtask

  // Called at a falling edge with inputs already set: checks ready, advances
  // the model across the next rising edge, then checks the outputs.
  task automatic tick();
    logic rdy, acc;
    #1;
    rdy = ce && (pos < 0 || pos == FLEN - 1);
    chk1("load_ready_m", load_ready_m, rdy);
    chk1("load_ready_l", load_ready_l, rdy);
    acc = load_valid && rdy;
    if (ce) begin
      if (acc) begin
        build(load_data);
        pos = 0;
      end else if (pos == FLEN - 1) begin
        pos = -1;
      end else if (pos >= 0) begin
        pos++;
      end
    end
    last_acc = acc;
    @(negedge clk);
    check_out();
  endtask

  task automatic send(input logic [WIDTH-1:0] w);
    load_valid = 1'b1;
    load_data  = w;
    last_acc   = 1'b0;
    for (int i = 0; i < 4 * FLEN && !last_acc; i++) tick();
    chk1("send_accepted", last_acc, 1'b1);
    load_valid = 1'b0;
    load_data  = WIDTH'($urandom);
  endtask

  initial begin
    reset_n = 1'b0; ce = 1'b1; load_valid = 1'b0; load_data = '0;
    #2;
    check_out();
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) tick();

    // Single frame 0xC4, bit order on both instances.
    send(8'hC4);
    for (int i = 0; i < WIDTH; i++) begin
      obs_m = {obs_m[WIDTH-2:0], ser_out_m};
      obs_l = {obs_l[WIDTH-2:0], ser_out_l};
      if (i < WIDTH - 1) tick();
    end
    chkw("order_msb_c4", obs_m, 8'hC4);
    chkw("order_lsb_c4", obs_l, 8'h23);
`ifdef SERIALIZER_PARITY_EN
    tick();
    chk1("parity_c4", ser_out_m, 1'b1);
`endif
    repeat (3) tick();

    // Back-to-back frames with load_valid held.
    send(8'hC4);
    send(8'h5A);
    repeat (FLEN + 2) tick();

    // Clock-enable stall after bit 3 with a competing load request.
    send(WIDTH'($urandom));
    repeat (2) tick();
    ce = 1'b0; load_valid = 1'b1; load_data = WIDTH'($urandom);
    repeat (3) tick();
    ce = 1'b1; load_valid = 1'b0;
    repeat (FLEN + 1) tick();

    // Asynchronous reset at bit 5, between edges.
    send(WIDTH'($urandom));
    repeat (4) tick();
    #2;
    reset_n = 1'b0;
    #1;
    pos = -1;
    check_out();
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) tick();

`ifdef SERIALIZER_PARITY_EN
    send(8'hC3);
    repeat (WIDTH) tick();
    chk1("parity_c3", ser_out_m, 1'b0);
    repeat (2) tick();
`endif

    // Randomised traffic with random ce.
    for (int n = 0; n < 400; n++) begin
      ce         = ($urandom_range(0, 3) != 0);
      load_valid = $urandom_range(0, 1) == 1;
      load_data  = WIDTH'($urandom);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
